// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding, host select codes and default widths.
package mem_responder_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;
  localparam logic SEL_IM = 1'b0;
  localparam logic SEL_DM = 1'b1;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int unsigned DEF_MAX_CYCLES = 32'hFFF0;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: core IM/DM, host access and run-control signals of the responder.
interface mem_responder_if import mem_responder_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
  logic [ADDR_WIDTH-1:0] im_addr, dm_addr, host_addr;
  logic [DATA_WIDTH-1:0] im_r_data, dm_w_data, dm_r_data, host_wdata, host_rdata;
  logic im_rd, dm_rd, dm_wr, start, stop;
  logic host_valid, host_ready, host_sel, host_we, host_rvalid, host_go;
  logic busy, done, timeout;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  modport slave (
    input im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data, stop,
    input host_valid, host_sel, host_we, host_addr, host_wdata, host_go,
    output im_r_data, dm_r_data, start, host_ready, host_rdata, host_rvalid,
    output busy, done, timeout, cycle_cnt
  );
  modport master (
    output im_addr, im_rd, dm_addr, dm_rd, dm_wr, dm_w_data, stop,
    output host_valid, host_sel, host_we, host_addr, host_wdata, host_go,
    input im_r_data, dm_r_data, start, host_ready, host_rdata, host_rvalid,
    input busy, done, timeout, cycle_cnt
  );
endinterface

// File: rtl/sp_ram_rf.sv
// sp_ram_rf: single-address RAM with one write port and a registered read-first read port.
module sp_ram_rf #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);
  localparam int IW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  assign idx = addr[IW-1:0];
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[idx];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: IM/DM target for the core plus host load/launch/readback port.
module mem_responder import mem_responder_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IM_DEPTH = DEF_DEPTH,
  parameter int DM_DEPTH = DEF_DEPTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES
) (
  input logic clk,
  input logic rst,
  mem_responder_if.slave bus
);
  state_t state;
  logic core_act, acc, host_rd, host_wr, go;
  logic im_re, im_we, dm_re, dm_we;
  logic [ADDR_WIDTH-1:0] im_a, dm_a;
  logic [DATA_WIDTH-1:0] im_q, dm_q, dm_wd, im_keep, dm_keep, host_keep;
  logic im_host, dm_host, host_src;
  logic [CNT_WIDTH-1:0] cnt_next;
  always_comb begin
    core_act = state == LAUNCH || state == RUN;
    acc = bus.host_valid && bus.host_ready;
    host_rd = acc && !bus.host_we;
    host_wr = acc && bus.host_we;
    im_re = core_act ? bus.im_rd : host_rd && bus.host_sel == SEL_IM;
    im_we = host_wr && bus.host_sel == SEL_IM;
    dm_re = core_act ? bus.dm_rd : host_rd && bus.host_sel == SEL_DM;
    dm_we = core_act ? bus.dm_wr : host_wr && bus.host_sel == SEL_DM;
    im_a = core_act ? bus.im_addr : bus.host_addr;
    dm_a = core_act ? bus.dm_addr : bus.host_addr;
    dm_wd = core_act ? bus.dm_w_data : bus.host_wdata;
    go = (state == IDLE || state == DONE) && bus.host_go && !bus.host_valid;
    cnt_next = &bus.cycle_cnt ? bus.cycle_cnt : bus.cycle_cnt + 1'b1;
  end
  sp_ram_rf #(.DEPTH(IM_DEPTH), .WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_im (
    .clk(clk), .rst(rst), .we(im_we), .re(im_re), .addr(im_a), .wdata(bus.host_wdata), .rdata(im_q)
  );
  sp_ram_rf #(.DEPTH(DM_DEPTH), .WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_dm (
    .clk(clk), .rst(rst), .we(dm_we), .re(dm_re), .addr(dm_a), .wdata(dm_wd), .rdata(dm_q)
  );
  // Each RAM has one read register shared by host and core; whoever lost it sees a snapshot.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      im_host <= 1'b0;
      dm_host <= 1'b0;
      host_src <= SEL_IM;
      im_keep <= '0;
      dm_keep <= '0;
      host_keep <= '0;
    end else begin
      if (core_act && bus.im_rd) begin
        im_host <= 1'b0;
        if (im_host && host_src == SEL_IM) host_keep <= im_q;
      end
      if (core_act && bus.dm_rd) begin
        dm_host <= 1'b0;
        if (dm_host && host_src == SEL_DM) host_keep <= dm_q;
      end
      if (host_rd) begin
        host_src <= bus.host_sel;
        if (bus.host_sel == SEL_IM) begin
          im_host <= 1'b1;
          if (!im_host) im_keep <= im_q;
        end else begin
          dm_host <= 1'b1;
          if (!dm_host) dm_keep <= dm_q;
        end
      end
    end
  assign bus.im_r_data = im_host ? im_keep : im_q;
  assign bus.dm_r_data = dm_host ? dm_keep : dm_q;
  assign bus.host_rdata = (host_src == SEL_DM ? dm_host : im_host) ? (host_src == SEL_DM ? dm_q : im_q) : host_keep;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.start <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.timeout <= 1'b0;
      bus.cycle_cnt <= '0;
      bus.host_ready <= 1'b0;
      bus.host_rvalid <= 1'b0;
    end else begin
      bus.host_rvalid <= host_rd;
      bus.start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          bus.host_ready <= !go;
          if (go) begin
            state <= LAUNCH;
            bus.start <= 1'b1;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            bus.timeout <= 1'b0;
            bus.cycle_cnt <= '0;
          end
        end
        LAUNCH: state <= RUN;
        RUN: begin
          bus.cycle_cnt <= cnt_next;
          if (bus.stop || cnt_next >= CNT_WIDTH'(MAX_CYCLES)) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.done <= bus.stop;
            bus.timeout <= !bus.stop;
            bus.host_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench with a memory-array reference model.
module tb_mem_responder;
  import mem_responder_pkg::*;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  mem_responder_if bus();
  mem_responder #(.MAX_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0, checks = 0;
  logic [15:0] im_m [256];
  logic [15:0] dm_m [256];
  logic [15:0] im_out = 0, dm_out = 0;
  logic [15:0] im_exp[$], dm_exp[$], host_exp[$];
  bit active = 0;
  int rc = 0;
  logic cap_im = 0, cap_dm = 0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  always @(posedge clk) begin
    cap_im <= bus.im_rd;
    cap_dm <= bus.dm_rd;
  end
  always @(negedge clk) begin
    if (cap_im) begin
      if (im_exp.size() == 0) chk("im_unexpected", 1, 0);
      else chk("im_r_data", bus.im_r_data, im_exp.pop_front());
    end
    if (cap_dm) begin
      if (dm_exp.size() == 0) chk("dm_unexpected", 1, 0);
      else chk("dm_r_data", bus.dm_r_data, dm_exp.pop_front());
    end
    if (bus.host_rvalid === 1'b1) begin
      if (host_exp.size() == 0) chk("host_rvalid_spurious", 1, 0);
      else chk("host_rdata", bus.host_rdata, host_exp.pop_front());
    end
  end
  task automatic host_acc(input logic sel, input logic we, input logic [7:0] a, input logic [15:0] d);
    int n = 0;
    bus.host_valid = 1; bus.host_sel = sel; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    while (bus.host_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("host_ready_wait", 0, 1);
    else if (we) begin
      if (sel == SEL_IM) im_m[a] = d;
      else dm_m[a] = d;
    end else host_exp.push_back(sel == SEL_IM ? im_m[a] : dm_m[a]);
    @(negedge clk);
    bus.host_valid = 0;
  endtask
  task automatic core_cyc(input logic ir, input logic dr, input logic dw, input logic [7:0] a, input logic [15:0] d);
    bus.im_rd = ir; bus.dm_rd = dr; bus.dm_wr = dw; bus.im_addr = a; bus.dm_addr = a; bus.dm_w_data = d;
    if (active && ir) im_out = im_m[a];
    if (active && dr) dm_out = dm_m[a];
    if (active && dw) dm_m[a] = d;
    if (ir) im_exp.push_back(im_out);
    if (dr) dm_exp.push_back(dm_out);
    @(negedge clk);
    bus.im_rd = 0; bus.dm_rd = 0; bus.dm_wr = 0;
    if (active) rc++;
  endtask
  task automatic do_go(input logic early_stop);
    bus.host_go = 1;
    @(negedge clk);
    chk("start_launch", bus.start, 1);
    chk("busy_launch", bus.busy, 1);
    chk("flags_cleared", {bus.done, bus.timeout}, 0);
    bus.host_go = 0;
    bus.stop = early_stop;
    active = 1;
    rc = 0;
    @(negedge clk);
    chk("start_one_cycle", bus.start, 0);
  endtask
  task automatic finish_run(input int stop_at);
    while (rc < stop_at - 1) core_cyc(0, 0, 0, 0, 0);
    bus.stop = 1;
    @(negedge clk);
    bus.stop = 0;
    active = 0;
    chk("done_set", bus.done, 1);
    chk("busy_clear", bus.busy, 0);
    chk("timeout_clear", bus.timeout, 0);
    chk("cycle_cnt_stop", bus.cycle_cnt, stop_at);
  endtask
  task automatic reset_model();
    active = 0;
    im_out = 0;
    dm_out = 0;
  endtask
  initial begin
    bus.im_addr = 0; bus.im_rd = 0; bus.dm_addr = 0; bus.dm_rd = 0; bus.dm_wr = 0; bus.dm_w_data = 0;
    bus.stop = 0; bus.host_valid = 0; bus.host_sel = 0; bus.host_we = 0; bus.host_addr = 0;
    bus.host_wdata = 0; bus.host_go = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {bus.start, bus.busy, bus.done, bus.timeout, bus.host_ready, bus.host_rvalid}, 0);
    chk("rst_cnt", bus.cycle_cnt, 0);
    chk("rst_rdata", {bus.im_r_data, bus.dm_r_data}, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      host_acc(SEL_IM, 1, 8'(i), 16'($urandom));
      host_acc(SEL_DM, 1, 8'(i), 16'($urandom));
    end
    for (int i = 0; i < 4; i++) host_acc(SEL_IM, 1, 8'(i), 16'(16'h1111 * (i + 1)));
    host_acc(SEL_IM, 0, 2, 0);
    host_acc(SEL_DM, 1, 5, 16'hAAAA);
    core_cyc(1, 1, 1, 5, 16'h0BAD);
    do_go(0);
    core_cyc(0, 1, 1, 5, 16'h5555);
    core_cyc(0, 1, 0, 5, 0);
    core_cyc(1, 0, 0, 2, 0);
    bus.host_valid = 1; bus.host_sel = SEL_DM; bus.host_we = 1; bus.host_addr = 5; bus.host_wdata = 16'hDEAD;
    repeat (3) begin
      @(negedge clk);
      rc++;
      chk("host_ready_run", bus.host_ready, 0);
    end
    bus.host_valid = 0;
    finish_run(12);
    host_acc(SEL_DM, 0, 5, 0);
    host_acc(SEL_IM, 0, 3, 0);
    core_cyc(1, 1, 1, 7, 16'h7777);
    host_acc(SEL_DM, 0, 7, 0);
    do_go(0);
    repeat (15) core_cyc(0, 0, 0, 0, 0);
    chk("busy_before_timeout", bus.busy, 1);
    chk("cnt_before_timeout", bus.cycle_cnt, 15);
    core_cyc(0, 0, 0, 0, 0);
    active = 0;
    chk("timeout_set", bus.timeout, 1);
    chk("timeout_done", bus.done, 0);
    chk("timeout_cnt", bus.cycle_cnt, 16);
    chk("timeout_busy", bus.busy, 0);
    do_go(1);
    @(negedge clk);
    active = 0;
    bus.stop = 0;
    chk("early_stop_done", {bus.done, bus.timeout}, 2'b10);
    chk("early_stop_cnt", bus.cycle_cnt, 1);
    for (int r = 0; r < 3; r++) begin
      repeat (8) host_acc(1'($urandom), 1, 8'($urandom), 16'($urandom));
      repeat (6) host_acc(1'($urandom), 0, 8'($urandom), 0);
      do_go(0);
      repeat ($urandom_range(4, 10))
        core_cyc(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
      finish_run(rc + 1 + int'($urandom_range(0, 3)));
      core_cyc(1, 1, 1'($urandom), 8'($urandom), 16'($urandom));
      repeat (4) host_acc(SEL_DM, 0, 8'($urandom), 0);
    end
    host_acc(SEL_DM, 1, 9, 16'h1234);
    do_go(0);
    core_cyc(0, 0, 1, 9, 16'h9999);
    core_cyc(0, 0, 0, 0, 0);
    rst = 1;
    #1;
    chk("rst_run_busy", bus.busy, 0);
    chk("rst_run_ready", bus.host_ready, 0);
    @(negedge clk);
    rst = 0;
    reset_model();
    host_acc(SEL_DM, 0, 9, 0);
    bus.host_go = 1;
    @(negedge clk);
    chk("launch_before_rst", bus.start, 1);
    rst = 1;
    #1;
    chk("rst_launch_start", bus.start, 0);
    chk("rst_launch_busy", bus.busy, 0);
    bus.host_go = 0;
    @(negedge clk);
    rst = 0;
    reset_model();
    host_acc(SEL_DM, 0, 5, 0);
    repeat (3) @(negedge clk);
    chk("queues_empty", im_exp.size() + dm_exp.size() + host_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
